// File: rtl/adder_tree_pkg.sv
// Width derivation shared by the adder tree, its accumulator and the bench.
// One definition of the log2 / SUM_W / ACC_W rules keeps all of them in step.
package adder_tree_pkg;

   function automatic int log2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Each tree level widens by one bit, so the full sum never overflows.
   function automatic int sum_w(input int w_in, input int n_in);
      return w_in + log2(n_in);
   endfunction

   function automatic int acc_w(input int sum_width, input int cnt_w);
      return sum_width + cnt_w;
   endfunction

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_CLEAR,
      ACC_ADD,
      ACC_DONE
   } acc_op_e;

endpackage

// File: rtl/adder_tree_acc.sv
// Windowed accumulator behind the adder tree: sums acc_len consecutive tree
// results and pulses acc_valid_o with the total when the window closes.
module adder_tree_acc
   import adder_tree_pkg::*;
#(
   parameter int SUM_W  = 8,
   parameter int CNT_W  = 4,
   localparam int ACC_W = acc_w(SUM_W, CNT_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [SUM_W-1:0] sum_i,
   input  logic             valid_i,
   input  logic [CNT_W-1:0] acc_len_i,
   input  logic             acc_clr_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             acc_valid_o
);

   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] len_q, len_n;
   logic [ACC_W-1:0] partial, partial_n;
   logic [ACC_W-1:0] acc_n;
   logic             acc_valid_n;

   acc_op_e          op;
   logic             idle;
   logic [CNT_W-1:0] win_len;
   logic [CNT_W-1:0] win_cnt;
   logic [ACC_W-1:0] win_total;

   // The length is only taken from acc_len_i when a window opens.
   assign idle      = (cnt == '0);
   assign win_len   = idle ? acc_len_i : len_q;
   assign win_cnt   = cnt + 1'b1;
   assign win_total = (idle ? '0 : partial) + {{CNT_W{1'b0}}, sum_i};

   // NOTE: every output of a combinational block gets a default before any
   // branch, otherwise an unassigned path infers a latch.
   always_comb begin
      op          = ACC_IDLE;
      cnt_n       = cnt;
      len_n       = len_q;
      partial_n   = partial;
      acc_n       = acc_o;
      acc_valid_n = 1'b0;

      if (acc_clr_i)
         op = ACC_CLEAR;
      else if (valid_i && !(idle && acc_len_i == '0))
         op = (win_cnt == win_len) ? ACC_DONE : ACC_ADD;

      case (op)
         ACC_CLEAR: begin
            cnt_n     = '0;
            partial_n = '0;
         end
         ACC_ADD: begin
            cnt_n     = win_cnt;
            len_n     = win_len;
            partial_n = win_total;
         end
         ACC_DONE: begin
            cnt_n       = '0;
            len_n       = win_len;
            partial_n   = '0;
            acc_n       = win_total;
            acc_valid_n = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         len_q       <= '0;
         partial     <= '0;
         acc_o       <= '0;
         acc_valid_o <= 1'b0;
      end else if (en_i) begin
         cnt         <= cnt_n;
         len_q       <= len_n;
         partial     <= partial_n;
         acc_o       <= acc_n;
         acc_valid_o <= acc_valid_n;
      end
   end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined unsigned adder tree: one input register stage plus log2(N_IN)
// pairwise-add stages, followed by a windowed accumulator on the tree output.
module adder_tree_pipe
   import adder_tree_pkg::*;
#(
   parameter int N_IN   = 16,
   parameter int W_IN   = 4,
   parameter int CNT_W  = 4,
   localparam int LG    = log2(N_IN),
   localparam int SUM_W = sum_w(W_IN, N_IN),
   localparam int ACC_W = acc_w(SUM_W, CNT_W)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 valid_i,
   input  logic [N_IN*W_IN-1:0] data_i,
   input  logic [CNT_W-1:0]     acc_len_i,
   input  logic                 acc_clr_i,
   output logic [SUM_W-1:0]     sum_o,
   output logic                 valid_o,
   output logic [ACC_W-1:0]     acc_o,
   output logic                 acc_valid_o
);

   // Stage s holds N_IN>>s operands of W_IN+s bits; valid rides alongside.
   for (genvar s = 0; s <= LG; s++) begin : stg
      localparam int CNT = N_IN >> s;
      localparam int W   = W_IN + s;

      logic [W-1:0] q [CNT];
      logic         v;

      if (s == 0) begin : g_in
         // NOTE: the pipeline arrays are plain registers, not RAM, so they
         // take the synchronous reset like any other flop.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < CNT; i++) q[i] <= '0;
               v <= 1'b0;
            end else if (en_i) begin
               for (int i = 0; i < CNT; i++) q[i] <= data_i[i*W_IN +: W_IN];
               v <= valid_i;
            end
         end
      end else begin : g_add
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < CNT; i++) q[i] <= '0;
               v <= 1'b0;
            end else if (en_i) begin
               for (int i = 0; i < CNT; i++)
                  q[i] <= {1'b0, stg[s-1].q[2*i]} + {1'b0, stg[s-1].q[2*i+1]};
               v <= stg[s-1].v;
            end
         end
      end
   end

   assign sum_o   = stg[LG].q[0];
   assign valid_o = stg[LG].v;

   adder_tree_acc #(
      .SUM_W (SUM_W),
      .CNT_W (CNT_W)
   ) u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en_i),
      .sum_i       (sum_o),
      .valid_i     (valid_o),
      .acc_len_i   (acc_len_i),
      .acc_clr_i   (acc_clr_i),
      .acc_o       (acc_o),
      .acc_valid_o (acc_valid_o)
   );

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe (N_IN=16, W_IN=4, CNT_W=4): latency,
// stalls, accumulation windows, clear and mid-flight reset.
module tb_adder_tree_pipe;
   import adder_tree_pkg::*;

   localparam int N_IN  = 16;
   localparam int W_IN  = 4;
   localparam int CNT_W = 4;
   localparam int SUM_W = sum_w(W_IN, N_IN);
   localparam int ACC_W = acc_w(SUM_W, CNT_W);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 en_i = 1'b1;
   logic                 valid_i = 1'b0;
   logic [N_IN*W_IN-1:0] data_i = '0;
   logic [CNT_W-1:0]     acc_len_i = '0;
   logic                 acc_clr_i = 1'b0;
   logic [SUM_W-1:0]     sum_o;
   logic                 valid_o;
   logic [ACC_W-1:0]     acc_o;
   logic                 acc_valid_o;

   adder_tree_pipe #(
      .N_IN  (N_IN),
      .W_IN  (W_IN),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .acc_len_i   (acc_len_i),
      .acc_clr_i   (acc_clr_i),
      .sum_o       (sum_o),
      .valid_o     (valid_o),
      .acc_o       (acc_o),
      .acc_valid_o (acc_valid_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int c0;
   int sq[$], sc[$], aq[$], ac[$];

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   // First k operands set to v, the rest zero.
   function automatic logic [N_IN*W_IN-1:0] vec(input int k, input int v);
      logic [N_IN*W_IN-1:0] d;
      d = '0;
      for (int i = 0; i < k; i++) d[i*W_IN +: W_IN] = v[W_IN-1:0];
      return d;
   endfunction

   // One clock; outputs sampled 1 time unit after the edge and logged.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (valid_o) begin
         sq.push_back(int'(sum_o));
         sc.push_back(cyc);
      end
      if (acc_valid_o) begin
         aq.push_back(int'(acc_o));
         ac.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [N_IN*W_IN-1:0] d);
      data_i  = d;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      data_i  = '0;
   endtask

   task automatic clr_q();
      sq.delete();
      sc.delete();
      aq.delete();
      ac.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got %0d cycles expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      idle(2);
      check("rst_sum", int'(sum_o), 0);
      check("rst_valid", int'(valid_o), 0);
      check("rst_acc", int'(acc_o), 0);
      check("rst_acc_valid", int'(acc_valid_o), 0);
      rst_n = 1'b1;
      idle(1);

      // Single full-scale vector: 16*15 = 240, five enabled edges of latency
      clr_q();
      c0 = cyc + 1;
      send(vec(16, 15));
      idle(6);
      check("max_count", sq.size(), 1);
      check("max_sum", qget(sq, 0), 240);
      check("max_cycle", qget(sc, 0), c0 + 4);

      // Back-to-back vectors
      clr_q();
      c0 = cyc + 1;
      send(vec(16, 1));
      send(vec(16, 2));
      send(vec(16, 3));
      idle(7);
      check("b2b_count", sq.size(), 3);
      check("b2b_sum0", qget(sq, 0), 16);
      check("b2b_sum1", qget(sq, 1), 32);
      check("b2b_sum2", qget(sq, 2), 48);
      check("b2b_cycle0", qget(sc, 0), c0 + 4);
      check("b2b_cycle2", qget(sc, 2), c0 + 6);

      // Same vectors with a 3-cycle stall mid-flight
      clr_q();
      c0 = cyc + 1;
      send(vec(16, 1));
      send(vec(16, 2));
      send(vec(16, 3));
      idle(1);
      en_i = 1'b0;
      idle(3);
      en_i = 1'b1;
      idle(6);
      check("stall_count", sq.size(), 3);
      check("stall_sum0", qget(sq, 0), 16);
      check("stall_sum1", qget(sq, 1), 32);
      check("stall_sum2", qget(sq, 2), 48);
      check("stall_cycle0", qget(sc, 0), c0 + 7);
      check("stall_cycle1", qget(sc, 1), c0 + 8);
      check("stall_cycle2", qget(sc, 2), c0 + 9);

      // Window of 3: 240 + 120 + 1 = 361; length change mid-window ignored
      clr_q();
      acc_len_i = 4'd3;
      c0 = cyc + 1;
      send(vec(16, 15));
      send(vec(8, 15));
      send(vec(1, 1));
      idle(3);
      acc_len_i = 4'd2;
      idle(5);
      check("win3_count", aq.size(), 1);
      check("win3_total", qget(aq, 0), 361);
      check("win3_cycle", qget(ac, 0), c0 + 7);
      check("win3_hold", int'(acc_o), 361);

      // Window of 1: every result completes one cycle after it appears
      clr_q();
      acc_len_i = 4'd1;
      c0 = cyc + 1;
      send(vec(16, 1));
      send(vec(5, 1));
      send(vec(16, 2));
      idle(6);
      check("win1_count", aq.size(), 3);
      check("win1_total0", qget(aq, 0), 16);
      check("win1_total1", qget(aq, 1), 5);
      check("win1_total2", qget(aq, 2), 32);
      check("win1_cycle0", qget(ac, 0), c0 + 5);
      check("win1_cycle2", qget(ac, 2), c0 + 7);

      // Accumulation off: sums flow, no completion, acc_o holds
      clr_q();
      acc_len_i = 4'd0;
      send(vec(16, 1));
      send(vec(16, 2));
      idle(6);
      check("off_sum_count", sq.size(), 2);
      check("off_acc_count", aq.size(), 0);
      check("off_acc_hold", int'(acc_o), 32);

      // Clear coincident with the second result of a 3-window
      clr_q();
      acc_len_i = 4'd3;
      c0 = cyc + 1;
      send(vec(7, 1));
      send(vec(9, 1));
      idle(4);
      acc_clr_i = 1'b1;
      idle(1);
      acc_clr_i = 1'b0;
      check("clr_no_done", aq.size(), 0);
      send(vec(10, 1));
      send(vec(10, 2));
      send(vec(15, 2));
      idle(6);
      check("clr_count", aq.size(), 1);
      check("clr_total", qget(aq, 0), 60);

      // Reset with four vectors in flight, en_i low during reset
      clr_q();
      acc_len_i = 4'd1;
      send(vec(16, 1));
      send(vec(16, 2));
      send(vec(16, 3));
      send(vec(16, 4));
      rst_n = 1'b0;
      en_i  = 1'b0;
      idle(1);
      check("mid_rst_sum", int'(sum_o), 0);
      check("mid_rst_valid", int'(valid_o), 0);
      check("mid_rst_acc", int'(acc_o), 0);
      check("mid_rst_acc_valid", int'(acc_valid_o), 0);
      rst_n = 1'b1;
      en_i  = 1'b1;
      idle(8);
      check("post_rst_sums", sq.size(), 0);
      check("post_rst_accs", aq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
